// File: rtl/seq_alu_if.sv
// seq_alu request/result bus: request handshake, operands and control,
// result handshake with flags, and multiplier busy indication.
interface seq_alu_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [5:0]       control;
  logic             mul;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             zr;
  logic             ng;
  logic             busy;

  modport master (
    output in_valid, x, y, control, mul, out_ready,
    input  in_ready, out_valid, out, zr, ng, busy
  );

  modport slave (
    input  in_valid, x, y, control, mul, out_ready,
    output in_ready, out_valid, out, zr, ng, busy
  );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: Hack-style ALU with registered result, zr/ng flags and a
// valid/ready result handshake. Optional WIDTH-step shift-add multiplier
// enabled by the SEQ_ALU_MUL_EN macro; without it, mul is ignored and
// every request completes in one cycle.
module seq_alu #(
  parameter int unsigned WIDTH = 16
) (
  input logic      clk,
  input logic      rst,
  seq_alu_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             zr_q, zr_d;
  logic             ng_q, ng_d;
  logic             ov_q, ov_d;
  logic             accept;
  logic [WIDTH-1:0] xp, yp, alu_res;
  logic             ld_en;
  logic [WIDTH-1:0] ld_val;

`ifdef SEQ_ALU_MUL_EN
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] acc_step;
  logic             no_q, no_d;
  logic [CW-1:0]    cnt_q, cnt_d;
`else
  logic unused_mul;
  assign unused_mul = bus.mul;
`endif

  assign bus.in_ready = (state_q != MUL) && (!ov_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  // Operand pre-stage and single-cycle ALU function on the live inputs
  always_comb begin
    xp = bus.control[0] ? '0 : bus.x;
    if (bus.control[1]) xp = ~xp;
    yp = bus.control[2] ? '0 : bus.y;
    if (bus.control[3]) yp = ~yp;
    alu_res = bus.control[4] ? (xp + yp) : (xp & yp);
    if (bus.control[5]) alu_res = ~alu_res;
  end

  // Next-state and datapath update; result load is shared by ALU and MUL paths
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    zr_d    = zr_q;
    ng_d    = ng_q;
    ov_d    = ov_q;
    ld_en   = 1'b0;
    ld_val  = '0;
`ifdef SEQ_ALU_MUL_EN
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    no_d     = no_q;
    cnt_d    = cnt_q;
    acc_step = acc_q + (b_q[0] ? a_q : '0);
`endif
    // Consumption first so a same-edge accept can re-assert out_valid
    if (ov_q && bus.out_ready) begin
      ov_d    = 1'b0;
      state_d = IDLE;
    end
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
`ifdef SEQ_ALU_MUL_EN
          if (bus.mul) begin
            state_d = MUL;
            a_d     = xp;
            b_d     = yp;
            acc_d   = '0;
            cnt_d   = '0;
            no_d    = bus.control[5];
          end else begin
            ld_en  = 1'b1;
            ld_val = alu_res;
          end
`else
          ld_en  = 1'b1;
          ld_val = alu_res;
`endif
        end
      end
      MUL: begin
`ifdef SEQ_ALU_MUL_EN
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        acc_d = acc_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          ld_en  = 1'b1;
          ld_val = no_q ? ~acc_step : acc_step;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
    if (ld_en) begin
      state_d = DONE;
      out_d   = ld_val;
      zr_d    = (ld_val == '0);
      ng_d    = ld_val[WIDTH-1];
      ov_d    = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Result and flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
      zr_q  <= 1'b0;
      ng_q  <= 1'b0;
      ov_q  <= 1'b0;
    end else begin
      out_q <= out_d;
      zr_q  <= zr_d;
      ng_q  <= ng_d;
      ov_q  <= ov_d;
    end
  end

`ifdef SEQ_ALU_MUL_EN
  // Shift-add multiplier registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      no_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
      no_q  <= no_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.busy = (state_q == MUL);
`else
  assign bus.busy = 1'b0;
`endif

  assign bus.out       = out_q;
  assign bus.zr        = zr_q;
  assign bus.ng        = ng_q;
  assign bus.out_valid = ov_q;

endmodule
